// File: rtl/clock_chain_pkg.sv
// Shared constants, counter type and HIGH-count helper for the clock_chain timebase.
// Optional runtime reload is built when CLOCK_CHAIN_RELOAD_EN is defined.
package clock_chain_pkg;

  localparam int unsigned CLOCK_CHAIN_MAX_STAGES = 8;
  localparam int unsigned CC_CNT_WIDTH           = 28;

  typedef logic [CC_CNT_WIDTH-1:0] cc_cnt_t;

  // Cycles per period that Level stays high; a nonzero duty never rounds down to zero.
  function automatic logic [63:0] high_count(input logic [63:0] div, input logic [6:0] duty);
    logic [63:0] h;
    h = (div * 64'(duty)) / 64'd100;
    if (h == '0 && duty != '0) h = 64'd1;
    return h;
  endfunction

endpackage

// File: rtl/clock_chain_if.sv
// Control/status bundle of clock_chain; reload ports exist only with CLOCK_CHAIN_RELOAD_EN.
interface clock_chain_if #(
  parameter int unsigned STAGES    = 4,
  parameter int unsigned CNT_WIDTH = 28
);
  localparam int unsigned SEL_W = (STAGES > 1) ? $clog2(STAGES) : 1;

  logic              Run;
  logic              SyncClr;
  logic [STAGES-1:0] Tick;
  logic [STAGES-1:0] Level;
  logic              Busy;
`ifdef CLOCK_CHAIN_RELOAD_EN
  logic                 DivWe;
  logic [SEL_W-1:0]     DivSel;
  logic [CNT_WIDTH-1:0] DivData;
  logic [CNT_WIDTH-1:0] HighData;

  modport master (output Run, SyncClr, DivWe, DivSel, DivData, HighData,
                  input  Tick, Level, Busy);
  modport slave  (input  Run, SyncClr, DivWe, DivSel, DivData, HighData,
                  output Tick, Level, Busy);
`else
  modport master (output Run, SyncClr, input  Tick, Level, Busy);
  modport slave  (input  Run, SyncClr, output Tick, Level, Busy);
`endif
endinterface

// File: rtl/clock_chain_stage.sv
// One timebase stage: modulo-DIV counter, wrap tick and registered duty-cycle level.
// With CLOCK_CHAIN_RELOAD_EN, a shadow divisor/high pair is applied at wrap or SyncClr.
module clock_chain_stage #(
  parameter int unsigned          CNT_WIDTH = 28,
  parameter logic [CNT_WIDTH-1:0] DIV       = 1,
  parameter logic [CNT_WIDTH-1:0] HIGH      = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic                 i_clr,
`ifdef CLOCK_CHAIN_RELOAD_EN
  input  logic                 i_we,
  input  logic [CNT_WIDTH-1:0] i_div,
  input  logic [CNT_WIDTH-1:0] i_high,
`endif
  output logic                 o_tick,
  output logic                 o_level,
  output logic                 o_busy
);

  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_level;
  logic [CNT_WIDTH-1:0] w_div;
  logic [CNT_WIDTH-1:0] w_high_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 w_wrap;

`ifdef CLOCK_CHAIN_RELOAD_EN
  logic [CNT_WIDTH-1:0] r_div, r_high, r_sh_div, r_sh_high;
  logic                 r_pend;
  logic                 w_apply;

  assign w_div      = r_div;
  assign w_apply    = (w_wrap || i_clr) && r_pend;
  assign w_high_nxt = w_apply ? r_sh_high : r_high;

  // A write coinciding with an apply lands in the shadow and waits for the next wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div     <= DIV;
      r_high    <= HIGH;
      r_sh_div  <= DIV;
      r_sh_high <= HIGH;
      r_pend    <= 1'b0;
    end else begin
      if (w_apply) begin
        r_div  <= r_sh_div;
        r_high <= r_sh_high;
      end
      if (i_we) begin
        r_sh_div  <= i_div;
        r_sh_high <= (i_high >= i_div) ? i_div : i_high;
        r_pend    <= 1'b1;
      end else if (w_apply) begin
        r_pend <= 1'b0;
      end
    end
  end
`else
  assign w_div      = DIV;
  assign w_high_nxt = HIGH;
`endif

  assign w_wrap = i_en && (r_cnt == w_div - 1'b1);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr)       w_cnt_nxt = '0;
    else if (w_wrap) w_cnt_nxt = '0;
    else if (i_en)   w_cnt_nxt = r_cnt + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_level <= (HIGH != '0);
    end else begin
      r_cnt <= w_cnt_nxt;
      if (i_en || i_clr) r_level <= (w_cnt_nxt < w_high_nxt);
    end
  end

  assign o_tick  = w_wrap;
  assign o_level = r_level;
  assign o_busy  = |r_cnt;

endmodule

// File: rtl/clock_chain.sv
// Enable-cascaded single-clock timebase chain of STAGES counters.
// Runtime divisor reload is built when CLOCK_CHAIN_RELOAD_EN is defined.
module clock_chain
  import clock_chain_pkg::*;
#(
  parameter int unsigned                  STAGES    = 4,
  parameter int unsigned                  CNT_WIDTH = 28,
  parameter logic [STAGES*CNT_WIDTH-1:0]  DIVISORS  = {28'd1000, 28'd1000, 28'd10, 28'd50},
  parameter logic [STAGES*7-1:0]          DUTY      = {7'd50, 7'd80, 7'd50, 7'd50}
) (
  input  logic          Clk,
  input  logic          Rst_n,
  clock_chain_if.slave  bus
);

  if (STAGES < 1 || STAGES > CLOCK_CHAIN_MAX_STAGES) begin : g_bad_stages
    $error("clock_chain: STAGES out of range");
  end

  logic [STAGES-1:0] w_en;
  logic [STAGES-1:0] w_tick;
  logic [STAGES-1:0] w_level;
  logic [STAGES-1:0] w_busy;
`ifdef CLOCK_CHAIN_RELOAD_EN
  logic [STAGES-1:0] w_we;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [CNT_WIDTH-1:0] DIV_K  = DIVISORS[k*CNT_WIDTH +: CNT_WIDTH];
    localparam logic [CNT_WIDTH-1:0] HIGH_K =
      CNT_WIDTH'(high_count(64'(DIV_K), DUTY[k*7 +: 7]));

    if (k == 0) begin : g_head
      assign w_en[k] = bus.Run & ~bus.SyncClr;
    end else begin : g_link
      assign w_en[k] = w_tick[k-1];
    end

`ifdef CLOCK_CHAIN_RELOAD_EN
    assign w_we[k] = bus.DivWe && (bus.DivData != '0) && (32'(bus.DivSel) == 32'(k));
`endif

    clock_chain_stage #(
      .CNT_WIDTH (CNT_WIDTH),
      .DIV       (DIV_K),
      .HIGH      (HIGH_K)
    ) u_stage (
      .i_clk   (Clk),
      .i_rst_n (Rst_n),
      .i_en    (w_en[k]),
      .i_clr   (bus.SyncClr),
`ifdef CLOCK_CHAIN_RELOAD_EN
      .i_we    (w_we[k]),
      .i_div   (bus.DivData),
      .i_high  (bus.HighData),
`endif
      .o_tick  (w_tick[k]),
      .o_level (w_level[k]),
      .o_busy  (w_busy[k])
    );
  end

  assign bus.Tick  = w_tick;
  assign bus.Level = w_level;
  assign bus.Busy  = |w_busy;

endmodule
